// File: rtl/i2c_slave_read_byte_pkg.sv
// Shared definitions for the I2C slave byte receiver.
//   - default byte width and bit-reader timeout
//   - FSM state encoding (3-bit) used by the receiver and visible to its bench
package i2c_slave_read_byte_pkg;

    localparam int DEFAULT_BYTE_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_BIT_EN    = 3'd2,
        ST_WAIT_BIT  = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERR       = 3'd5
    } rd_state_t;

endpackage

// File: rtl/i2c_slave_read_byte_if.sv
// Signal bundle between the slave control FSM, the byte receiver and the
// bit-level reader.
//   slave  modport : the byte receiver's view
//   master modport : the surrounding logic (control FSM, bit reader, pads)
// Signals:
//   scl_i            synchronised SCL
//   byte_read_en     one-cycle start request
//   byte_read_o      assembled byte (valid with finish and no error)
//   byte_read_err    one-cycle abort pulse
//   byte_read_finish one-cycle end-of-transfer pulse
//   bit_read_en      one-cycle request to the bit reader
//   bit_read_o       bit returned by the bit reader
//   bit_read_err     bit reader detected SDA change while SCL high
//   bit_read_finish  one-cycle pulse, bit_read_o valid
interface i2c_slave_read_byte_if
    import i2c_slave_read_byte_pkg::*;
#(
    parameter int BYTE_WIDTH = DEFAULT_BYTE_WIDTH
);
    logic                  scl_i;
    logic                  byte_read_en;
    logic [BYTE_WIDTH-1:0] byte_read_o;
    logic                  byte_read_err;
    logic                  byte_read_finish;
    logic                  bit_read_en;
    logic                  bit_read_o;
    logic                  bit_read_err;
    logic                  bit_read_finish;

    modport slave (
        input  scl_i,
        input  byte_read_en,
        output byte_read_o,
        output byte_read_err,
        output byte_read_finish,
        output bit_read_en,
        input  bit_read_o,
        input  bit_read_err,
        input  bit_read_finish
    );

    modport master (
        output scl_i,
        output byte_read_en,
        input  byte_read_o,
        input  byte_read_err,
        input  byte_read_finish,
        input  bit_read_en,
        output bit_read_o,
        output bit_read_err,
        output bit_read_finish
    );
endinterface

// File: rtl/i2c_slave_read_byte_scl_edge.sv
// SCL rising-edge detector.
//   clk       system clock
//   rst       synchronous active-high reset
//   scl_i     synchronised SCL
//   scl_rise  high for one cycle when SCL was low last cycle and is high now
// scl_last resets to 1 so that a line already high out of reset does not
// register as a rising edge.
module i2c_slave_read_byte_scl_edge (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    output logic scl_rise
);
    logic scl_last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_last_reg <= 1'b1;
        end else begin
            scl_last_reg <= scl_i;
        end
    end

    assign scl_rise = ~scl_last_reg & scl_i;

endmodule

// File: rtl/i2c_slave_read_byte.sv
// I2C slave byte receiver. Requests one bit from the bit reader per SCL
// high phase and packs BYTE_WIDTH bits MSB-first into a parallel byte.
// Parameters:
//   BYTE_WIDTH      bits per transfer (>= 2)
//   TIMEOUT_CYCLES  clk cycles allowed from bit_read_en to bit_read_finish (>= 2)
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  i2c_slave_read_byte_if slave modport (see interface file)
module i2c_slave_read_byte
    import i2c_slave_read_byte_pkg::*;
#(
    parameter int BYTE_WIDTH     = DEFAULT_BYTE_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_slave_read_byte_if.slave  bus
);
    localparam int CNT_W = $clog2(BYTE_WIDTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

    rd_state_t             state_reg, state_next;
    logic [BYTE_WIDTH-1:0] shreg_reg, shreg_next;
    logic [BYTE_WIDTH-1:0] byte_reg, byte_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [TMO_W-1:0]      tmo_reg, tmo_next;

    logic                  scl_rise;
    logic [BYTE_WIDTH-1:0] shreg_shifted;
    logic [TMO_W-1:0]      tmo_inc;

    i2c_slave_read_byte_scl_edge u_scl_edge (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (bus.scl_i),
        .scl_rise (scl_rise)
    );

    assign shreg_shifted = {shreg_reg[BYTE_WIDTH-2:0], bus.bit_read_o};
    // Saturating increment: the counter sticks at its limit instead of wrapping.
    assign tmo_inc = (tmo_reg == TMO_MAX) ? tmo_reg : tmo_reg + TMO_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            byte_reg  <= '0;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            byte_reg  <= byte_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        byte_next  = byte_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;

        unique case (state_reg)
            ST_IDLE: begin
                tmo_next = '0;
                if (bus.byte_read_en) begin
                    shreg_next = '0;
                    cnt_next   = '0;
                    state_next = ST_WAIT_RISE;
                end
            end

            ST_WAIT_RISE: begin
                if (scl_rise) begin
                    // Counter reads 0 during BIT_EN, so an abort lands exactly
                    // TIMEOUT_CYCLES cycles after the bit_read_en pulse.
                    tmo_next   = '0;
                    state_next = ST_BIT_EN;
                end
            end

            ST_BIT_EN: begin
                tmo_next   = tmo_inc;
                state_next = ST_WAIT_BIT;
            end

            ST_WAIT_BIT: begin
                tmo_next = tmo_inc;
                if (bus.bit_read_err) begin
                    byte_next  = '0;
                    state_next = ST_ERR;
                end else if (bus.bit_read_finish) begin
                    shreg_next = shreg_shifted;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        // Output register is loaded on the way into DONE so the
                        // byte is already valid during the finish pulse.
                        byte_next  = shreg_shifted;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT_RISE;
                    end
                end else if (tmo_reg == TMO_MAX) begin
                    byte_next  = '0;
                    state_next = ST_ERR;
                end
            end

            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.bit_read_en      = (state_reg == ST_BIT_EN);
    assign bus.byte_read_finish = (state_reg == ST_DONE) || (state_reg == ST_ERR);
    assign bus.byte_read_err    = (state_reg == ST_ERR);
    assign bus.byte_read_o      = byte_reg;

endmodule
